// File: rtl/ram_pkg.sv
// Shared types and constants for the byte-enable synchronous RAM.
package ram_pkg;

   typedef enum logic {
      ST_CLEAR = 1'b0,
      ST_READY = 1'b1
   } state_t;

   localparam int BYTE_W     = 8;
   localparam int RD_LAT_MIN = 1;
   localparam int RD_LAT_MAX = 3;

   function automatic int lane_cnt(input int data_w);
      return data_w / BYTE_W;
   endfunction

endpackage

// File: rtl/ram_rd_pipe.sv
// Read-response delay line carrying {valid, err, data}; data/err stages only load on valid,
// so the output holds the last response while valid is low. No backpressure.
module ram_rd_pipe #(
   parameter int DATA_W = 32,
   parameter int LAT    = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_vld,
   input  logic              in_err,
   input  logic [DATA_W-1:0] in_dat,
   output logic              out_vld,
   output logic              out_err,
   output logic [DATA_W-1:0] out_dat
);

   logic [LAT-1:0]    vld_q, vld_d;
   logic [LAT-1:0]    err_q, err_d;
   logic [DATA_W-1:0] dat_q [LAT];
   logic [DATA_W-1:0] dat_d [LAT];

   always_comb begin
      vld_d    = '0;
      err_d    = err_q;
      dat_d    = dat_q;
      vld_d[0] = in_vld;
      if (in_vld) begin
         err_d[0] = in_err;
         dat_d[0] = in_dat;
      end
      for (int i = 1; i < LAT; i++) begin
         vld_d[i] = vld_q[i-1];
         if (vld_q[i-1]) begin
            err_d[i] = err_q[i-1];
            dat_d[i] = dat_q[i-1];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_q <= '0;
         err_q <= '0;
         dat_q <= '{default: '0};
      end else begin
         vld_q <= vld_d;
         err_q <= err_d;
         dat_q <= dat_d;
      end
   end

   assign out_vld = vld_q[LAT-1];
   assign out_err = err_q[LAT-1];
   assign out_dat = dat_q[LAT-1];

endmodule

// File: rtl/ram_sync_be.sv
// Synchronous single-port RAM with byte-enable writes, READ_LAT-cycle reads and a post-reset
// zero-fill; req_ready stays low while clearing, responses have no backpressure.
module ram_sync_be
   import ram_pkg::*;
#(
   parameter int DATA_W         = 32,
   parameter int ADDR_W         = 16,
   parameter int DEPTH          = 65536,
   parameter int READ_LAT       = 1,
   parameter int CLEAR_ON_RESET = 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic                req_we,
   input  logic [DATA_W/8-1:0] req_be,
   input  logic [ADDR_W-1:0]   req_addr,
   input  logic [DATA_W-1:0]   req_wdata,
   output logic                rsp_valid,
   output logic [DATA_W-1:0]   rsp_rdata,
   output logic                rsp_err,
   output logic                busy
);

   localparam int               LANES  = lane_cnt(DATA_W);
   localparam int               IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [IDX_W-1:0] LAST   = IDX_W'(DEPTH - 1);
   localparam state_t           RST_ST = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;

   generate
      if (DATA_W % BYTE_W != 0) begin : g_bad_data_w
         $error("DATA_W must be a multiple of 8");
      end
      if (DEPTH < 1 || longint'(DEPTH) > (64'd1 << ADDR_W)) begin : g_bad_depth
         $error("DEPTH must be in 1..2**ADDR_W");
      end
      if (READ_LAT < RD_LAT_MIN || READ_LAT > RD_LAT_MAX) begin : g_bad_lat
         $error("READ_LAT out of range");
      end
   endgenerate

   logic [DATA_W-1:0] mem [DEPTH];

   state_t            state_q, state_d;
   logic [IDX_W-1:0]  cnt_q, cnt_d;
   logic              clr_en;
   logic              rdy_st;
   logic              in_range;
   logic [IDX_W-1:0]  idx;
   logic              fire;
   logic              wr_fire;
   logic              rd_fire;
   logic [DATA_W-1:0] rd_dat;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      clr_en  = 1'b0;
      rdy_st  = 1'b0;
      busy    = 1'b0;
      unique case (state_q)
         ST_CLEAR: begin
            busy   = 1'b1;
            clr_en = !rst;
            if (cnt_q == LAST) begin
               cnt_d   = '0;
               state_d = ST_READY;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_READY: rdy_st = 1'b1;
         default:  state_d = RST_ST;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= RST_ST;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Ready is masked by rst so it reads 0 during reset even when no clear is configured.
   assign req_ready = rdy_st && !rst;
   assign in_range  = ({1'b0, req_addr} < (ADDR_W+1)'(DEPTH));
   assign idx       = req_addr[IDX_W-1:0];
   assign fire      = req_valid && req_ready;
   assign wr_fire   = fire && req_we && in_range;
   assign rd_fire   = fire && !req_we;
   assign rd_dat    = in_range ? mem[idx] : '0;

   always_ff @(posedge clk) begin
      if (clr_en) begin
         mem[cnt_q] <= '0;
      end else if (wr_fire) begin
         for (int i = 0; i < LANES; i++) begin
            if (req_be[i]) begin
               mem[idx][BYTE_W*i +: BYTE_W] <= req_wdata[BYTE_W*i +: BYTE_W];
            end
         end
      end
   end

   ram_rd_pipe #(
      .DATA_W (DATA_W),
      .LAT    (READ_LAT)
   ) u_rd_pipe (
      .clk     (clk),
      .rst     (rst),
      .in_vld  (rd_fire),
      .in_err  (!in_range),
      .in_dat  (rd_dat),
      .out_vld (rsp_valid),
      .out_err (rsp_err),
      .out_dat (rsp_rdata)
   );

endmodule

// File: tb/tb_ram_sync_be.sv
// Randomized and directed bench for ram_sync_be against a word-array reference model.
module tb_ram_sync_be;

   localparam int DATA_W = 32;
   localparam int ADDR_W = 4;
   localparam int DEPTH  = 12;
   localparam int LAT    = 3;

   logic              clk = 1'b0;
   logic              rst;
   logic              req_valid;
   logic              req_ready;
   logic              req_we;
   logic [3:0]        req_be;
   logic [ADDR_W-1:0] req_addr;
   logic [DATA_W-1:0] req_wdata;
   logic              rsp_valid;
   logic [DATA_W-1:0] rsp_rdata;
   logic              rsp_err;
   logic              busy;

   ram_sync_be #(
      .DATA_W         (DATA_W),
      .ADDR_W         (ADDR_W),
      .DEPTH          (DEPTH),
      .READ_LAT       (LAT),
      .CLEAR_ON_RESET (1)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_we    (req_we),
      .req_be    (req_be),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .rsp_valid (rsp_valid),
      .rsp_rdata (rsp_rdata),
      .rsp_err   (rsp_err),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          due;
      logic [31:0] dat;
      logic        err;
   } rsp_t;

   int          checks   = 0;
   int          failures = 0;
   int          edge_n   = 0;
   int          clr_left = 0;
   logic [31:0] mdl [DEPTH];
   rsp_t        pend [$];
   logic [31:0] last_dat = '0;
   logic        last_err = 1'b0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h at edge %0d", tag, got, exp, edge_n);
      end
   endtask

   // One clock: drive a request, let the model take the edge, then compare every output.
   task automatic step(input logic v, input logic we, input logic [3:0] be,
                       input logic [3:0] addr, input logic [31:0] wd);
      logic exp_v;
      rsp_t r;
      req_valid = v;
      req_we    = we;
      req_be    = be;
      req_addr  = addr;
      req_wdata = wd;
      @(posedge clk);
      edge_n++;
      if (clr_left > 0) begin
         clr_left--;
      end else if (v) begin
         if (we) begin
            if (int'(addr) < DEPTH)
               for (int i = 0; i < 4; i++)
                  if (be[i]) mdl[addr][8*i +: 8] = wd[8*i +: 8];
         end else begin
            r.due = edge_n + LAT - 1;
            r.err = (int'(addr) >= DEPTH);
            r.dat = r.err ? 32'h0 : mdl[addr];
            pend.push_back(r);
         end
      end
      @(negedge clk);
      exp_v = (pend.size() > 0) && (pend[0].due == edge_n);
      if (exp_v) begin
         r        = pend.pop_front();
         last_dat = r.dat;
         last_err = r.err;
      end
      chk("rsp_valid", 32'(rsp_valid), 32'(exp_v));
      chk("rsp_rdata", rsp_rdata, last_dat);
      chk("rsp_err",   32'(rsp_err), 32'(last_err));
      chk("busy",      32'(busy), 32'(clr_left > 0));
      chk("req_ready", 32'(req_ready), 32'(clr_left == 0));
   endtask

   task automatic idle();
      step(1'b0, 1'b0, 4'h0, 4'h0, 32'h0);
   endtask

   task automatic rnd_step();
      step(1'($urandom_range(0, 3) != 0), 1'($urandom), 4'($urandom),
           4'($urandom_range(0, 15)), $urandom);
   endtask

   task automatic do_reset(input int hold);
      rst = 1'b1;
      #1;
      chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
      chk("rst_rsp_rdata", rsp_rdata, 32'h0);
      chk("rst_rsp_err",   32'(rsp_err), 32'h0);
      chk("rst_busy",      32'(busy), 32'h1);
      chk("rst_req_ready", 32'(req_ready), 32'h0);
      pend.delete();
      last_dat = '0;
      last_err = 1'b0;
      repeat (hold) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      clr_left = DEPTH;
      for (int i = 0; i < DEPTH; i++) mdl[i] = '0;
      #1;
      chk("rel_busy",      32'(busy), 32'h1);
      chk("rel_req_ready", 32'(req_ready), 32'h0);
   endtask

   initial begin
      rst       = 1'b0;
      req_valid = 1'b0;
      req_we    = 1'b0;
      req_be    = '0;
      req_addr  = '0;
      req_wdata = '0;
      #2;
      do_reset(3);

      // Clear phase with requests offered that must be ignored.
      repeat (DEPTH) rnd_step();
      for (int a = 0; a < 16; a++) step(1'b1, 1'b0, 4'h0, 4'(a), 32'h0);
      repeat (LAT) idle();

      // Byte-lane merge.
      step(1'b1, 1'b1, 4'b1111, 4'd5, 32'hAABBCCDD);
      step(1'b1, 1'b1, 4'b0101, 4'd5, 32'h11223344);
      step(1'b1, 1'b0, 4'h0, 4'd5, 32'h0);
      idle();
      idle();
      chk("be_merge", rsp_rdata, 32'hAA22CC44);

      // Back-to-back reads with latency 3.
      step(1'b1, 1'b1, 4'hF, 4'd1, 32'h1);
      step(1'b1, 1'b1, 4'hF, 4'd2, 32'h2);
      step(1'b1, 1'b1, 4'hF, 4'd3, 32'h3);
      step(1'b1, 1'b0, 4'h0, 4'd1, 32'h0);
      step(1'b1, 1'b0, 4'h0, 4'd2, 32'h0);
      step(1'b1, 1'b0, 4'h0, 4'd3, 32'h0);
      chk("lat_rd1", rsp_rdata, 32'h1);
      idle();
      chk("lat_rd2", rsp_rdata, 32'h2);
      idle();
      chk("lat_rd3", rsp_rdata, 32'h3);
      idle();

      // Out-of-range write dropped, read flagged.
      step(1'b1, 1'b1, 4'hF, 4'd13, 32'hFFFFFFFF);
      step(1'b1, 1'b0, 4'h0, 4'd13, 32'h0);
      idle();
      idle();
      chk("oor_err", 32'(rsp_err), 32'h1);
      chk("oor_dat", rsp_rdata, 32'h0);
      step(1'b1, 1'b0, 4'h0, 4'd11, 32'h0);
      idle();
      idle();
      chk("inr_err", 32'(rsp_err), 32'h0);
      chk("inr_dat", rsp_rdata, 32'h0);

      // Write followed immediately by read, then an all-lanes-off write.
      step(1'b1, 1'b1, 4'hF, 4'd0, 32'hDEADBEEF);
      step(1'b1, 1'b0, 4'h0, 4'd0, 32'h0);
      idle();
      idle();
      chk("wr_rd", rsp_rdata, 32'hDEADBEEF);
      step(1'b1, 1'b1, 4'h0, 4'd0, 32'h12345678);
      step(1'b1, 1'b0, 4'h0, 4'd0, 32'h0);
      idle();
      idle();
      chk("be_zero", rsp_rdata, 32'hDEADBEEF);

      repeat (400) rnd_step();

      // Reset with a read in flight, then reset again part-way through the clear.
      step(1'b1, 1'b0, 4'h0, 4'd2, 32'h0);
      do_reset(2);
      repeat (7) rnd_step();
      do_reset(2);
      repeat (DEPTH) rnd_step();
      repeat (200) rnd_step();
      repeat (LAT) idle();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
